// File: rtl/regfile_writeback_if.sv
// Handshake, write-port and scoreboard-query bundle for regfile_writeback.
// The master side feeds results and query addresses. The slave side is the writeback queue.
interface regfile_writeback_if #(
    parameter int DWIDTH    = 32,
    parameter int RSELWIDTH = 5,
    parameter int DEPTH     = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                 alu_valid;
    logic                 alu_ready;
    logic [RSELWIDTH-1:0] alu_address;
    logic [DWIDTH-1:0]    alu_data;
    logic                 mem_valid;
    logic                 mem_ready;
    logic [RSELWIDTH-1:0] mem_address;
    logic [DWIDTH-1:0]    mem_data;
    logic                 write_en;
    logic [RSELWIDTH-1:0] write_address;
    logic [DWIDTH-1:0]    write_data;
    logic [RSELWIDTH-1:0] query_address1;
    logic [RSELWIDTH-1:0] query_address2;
    logic                 busy1;
    logic                 busy2;
    logic [CW-1:0]        count;

    modport master (
        output alu_valid, alu_address, alu_data,
        output mem_valid, mem_address, mem_data,
        output query_address1, query_address2,
        input  alu_ready, mem_ready, write_en, write_address, write_data,
        input  busy1, busy2, count
    );

    modport slave (
        input  alu_valid, alu_address, alu_data,
        input  mem_valid, mem_address, mem_data,
        input  query_address1, query_address2,
        output alu_ready, mem_ready, write_en, write_address, write_data,
        output busy1, busy2, count
    );
endinterface

// File: rtl/regfile_writeback.sv
// Writeback queue that merges ALU and load results into one register-file write port.
// It pops one entry per cycle and reports pending writes to decode.
module regfile_writeback #(
    parameter int DWIDTH    = 32,
    parameter int RSELWIDTH = 5,
    parameter int DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_writeback_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [RSELWIDTH-1:0] R0 = {RSELWIDTH{1'b0}};

    logic [RSELWIDTH-1:0] addr_q [DEPTH];
    logic [RSELWIDTH-1:0] addr_d [DEPTH];
    logic [DWIDTH-1:0]    data_q [DEPTH];
    logic [DWIDTH-1:0]    data_d [DEPTH];
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 write_en_q, write_en_d;
    logic [RSELWIDTH-1:0] write_address_q, write_address_d;
    logic [DWIDTH-1:0]    write_data_q, write_data_d;

    logic [CW-1:0]        free_s;
    logic                 mem_push_s, alu_push_s, pop_s;
    logic [PW-1:0]        alu_slot_s;
    logic [DEPTH-1:0]     entry_vld_s;
    logic                 hit1_s, hit2_s;

    // Readiness: a same-cycle pop never frees a slot for that cycle's push.
    always_comb begin
        free_s = CW'(DEPTH) - count_q;
        if (rst) begin
            bus.mem_ready = 1'b0;
            bus.alu_ready = 1'b0;
        end else begin
            bus.mem_ready = (free_s >= CW'(1));
            bus.alu_ready = (free_s >= CW'(2)) || ((free_s >= CW'(1)) && !bus.mem_valid);
        end
    end

    assign mem_push_s = bus.mem_valid && bus.mem_ready && (bus.mem_address != R0);
    assign alu_push_s = bus.alu_valid && bus.alu_ready && (bus.alu_address != R0);
    assign pop_s      = (count_q != CW'(0));

    // Queue next state. The load entry goes ahead of the ALU entry.
    always_comb begin
        addr_d          = addr_q;
        data_d          = data_q;
        rd_ptr_d        = rd_ptr_q;
        write_en_d      = pop_s;
        write_address_d = write_address_q;
        write_data_d    = write_data_q;
        alu_slot_s      = wr_ptr_q + PW'(mem_push_s);
        if (pop_s) begin
            write_address_d = addr_q[rd_ptr_q];
            write_data_d    = data_q[rd_ptr_q];
            rd_ptr_d        = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d        = rd_ptr_q;
        end
        if (mem_push_s) begin
            addr_d[wr_ptr_q] = bus.mem_address;
            data_d[wr_ptr_q] = bus.mem_data;
        end else begin
            addr_d[wr_ptr_q] = addr_d[wr_ptr_q];
        end
        if (alu_push_s) begin
            addr_d[alu_slot_s] = bus.alu_address;
            data_d[alu_slot_s] = bus.alu_data;
        end else begin
            addr_d[alu_slot_s] = addr_d[alu_slot_s];
        end
        wr_ptr_d = wr_ptr_q + PW'(mem_push_s) + PW'(alu_push_s);
        count_d  = count_q + CW'(mem_push_s) + CW'(alu_push_s) - CW'(pop_s);
    end

    // State registers. Reset empties the queue without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= R0;
                data_q[i] <= {DWIDTH{1'b0}};
            end
            rd_ptr_q        <= {PW{1'b0}};
            wr_ptr_q        <= {PW{1'b0}};
            count_q         <= {CW{1'b0}};
            write_en_q      <= 1'b0;
            write_address_q <= R0;
            write_data_q    <= {DWIDTH{1'b0}};
        end else begin
            addr_q          <= addr_d;
            data_q          <= data_d;
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            count_q         <= count_d;
            write_en_q      <= write_en_d;
            write_address_q <= write_address_d;
            write_data_q    <= write_data_d;
        end
    end

    // An entry is live when its distance past the read pointer is below count.
    always_comb begin
        entry_vld_s = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            entry_vld_s[i] = ({1'b0, PW'(i) - rd_ptr_q} < count_q);
        end
    end

    // Pending-write lookup covers the queue and the write currently on the port.
    always_comb begin
        hit1_s = write_en_q && (write_address_q == bus.query_address1);
        hit2_s = write_en_q && (write_address_q == bus.query_address2);
        for (int i = 0; i < DEPTH; i++) begin
            hit1_s = hit1_s | (entry_vld_s[i] && (addr_q[i] == bus.query_address1));
            hit2_s = hit2_s | (entry_vld_s[i] && (addr_q[i] == bus.query_address2));
        end
        bus.busy1 = hit1_s && (bus.query_address1 != R0);
        bus.busy2 = hit2_s && (bus.query_address2 != R0);
    end

    assign bus.write_en      = write_en_q;
    assign bus.write_address = write_address_q;
    assign bus.write_data    = write_data_q;
    assign bus.count         = count_q;
endmodule
